// File: rtl/gpio_capture_pkg.sv
// Shared constants and the event record for the GPIO capture block.
// The event record is sized by GPIO_WIDTH; instantiate gpio_capture with WIDTH equal to it.
package gpio_capture_pkg;

    localparam int GPIO_WIDTH       = 32;
    localparam int GPIO_SYNC_STAGES = 2;
    localparam int GPIO_EVT_DEPTH   = 4;

    typedef struct packed {
        logic [GPIO_WIDTH-1:0] mask;
        logic [GPIO_WIDTH-1:0] data;
    } gpio_evt_t;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Event FIFO: circular storage plus a registered head slot, so that head data
// never comes combinationally from the storage array. Occupancy counts both.
module gpio_evt_fifo
    import gpio_capture_pkg::*;
#(
    parameter int DEPTH = GPIO_EVT_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  gpio_evt_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output gpio_evt_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    gpio_evt_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   mem_count;
    logic [CW-1:0]   total;
    logic            head_valid;
    logic            do_pop;
    logic            do_push;
    logic            mem_rd;

    assign empty   = ~head_valid;
    assign total   = mem_count + CW'(head_valid);
    assign full    = (total == CW'(DEPTH));
    assign do_pop  = pop & head_valid;
    // A pop frees a slot in the same cycle, so a push on a full FIFO is kept.
    assign do_push = push & (~full | do_pop);
    assign mem_rd  = (mem_count != '0) & (~head_valid | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mem_count <= mem_count + CW'(do_push) - CW'(mem_rd);
            if (mem_rd) begin
                head       <= mem[rd_ptr];
                head_valid <= 1'b1;
            end else if (do_pop) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpio_capture.sv
// GPIO receive block: synchronizes pins and ext_clk, captures per bit on clk or an
// ext_clk edge, and queues every change of gpio_q as an event. Optional irq output: GPIO_CAPTURE_IRQ_EN.
module gpio_capture
    import gpio_capture_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int FIFO_DEPTH  = GPIO_EVT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             ext_clk,
    input  logic [WIDTH-1:0] use_ext_clk,
    input  logic [WIDTH-1:0] ext_clk_edge,
    output logic [WIDTH-1:0] gpio_q,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_ovf,
    input  logic             ovf_clr
`ifdef GPIO_CAPTURE_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] gpio_sync;
    logic [SYNC_STAGES-1:0]            ext_sync;
    logic [WIDTH-1:0]                  gpio_s;
    logic                              ext_s;
    logic                              ext_d;
    logic                              rise;
    logic                              fall;
    logic [WIDTH-1:0]                  cap_en;
    logic [WIDTH-1:0]                  gpio_q_d;
    logic [WIDTH-1:0]                  chg;
    logic                              evt_push;
    logic                              evt_pop;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic                              drop;
    gpio_evt_t                         evt_in;
    gpio_evt_t                         evt_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_sync <= '0;
            ext_sync  <= '0;
            ext_d     <= 1'b0;
        end else begin
            gpio_sync <= {gpio_sync[SYNC_STAGES-2:0], gpio_in};
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_clk};
            ext_d     <= ext_s;
        end
    end

    assign gpio_s = gpio_sync[SYNC_STAGES-1];
    assign ext_s  = ext_sync[SYNC_STAGES-1];
    assign rise   = ext_s & ~ext_d;
    assign fall   = ~ext_s & ext_d;

    // Per-bit load enable: always for clk-captured bits, else only on the selected strobe edge.
    assign cap_en = ~use_ext_clk
                  | (use_ext_clk & ext_clk_edge & {WIDTH{rise}})
                  | (use_ext_clk & ~ext_clk_edge & {WIDTH{fall}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q   <= '0;
            gpio_q_d <= '0;
        end else begin
            gpio_q   <= (gpio_q & ~cap_en) | (gpio_s & cap_en);
            gpio_q_d <= gpio_q;
        end
    end

    assign chg         = gpio_q ^ gpio_q_d;
    assign evt_push    = |chg;
    assign evt_in.mask = chg;
    assign evt_in.data = gpio_q;
    assign evt_valid   = ~fifo_empty;
    assign evt_pop     = evt_valid & evt_ready;
    assign drop        = evt_push & fifo_full & ~evt_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_ovf <= 1'b0;
        end else if (drop) begin
            evt_ovf <= 1'b1;
        end else if (ovf_clr) begin
            evt_ovf <= 1'b0;
        end
    end

    gpio_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (evt_push),
        .push_data (evt_in),
        .pop       (evt_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (evt_head)
    );

    assign evt_mask = evt_head.mask;
    assign evt_data = evt_head.data;

`ifdef GPIO_CAPTURE_IRQ_EN
    // Non-empty is judged by the visible head, so irq trails evt_valid by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= evt_valid | evt_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_capture.sv
// Bench for gpio_capture: directed scenarios plus random traffic checked each cycle
// against a history-based reference model and an event scoreboard.
module tb_gpio_capture;

    localparam int W = 32;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gpio_in = '0;
    logic         ext_clk = 1'b0;
    logic [W-1:0] use_ext_clk = '0;
    logic [W-1:0] ext_clk_edge = '0;
    logic         evt_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] gpio_q;
    logic         evt_valid;
    logic [W-1:0] evt_mask;
    logic [W-1:0] evt_data;
    logic         evt_ovf;
`ifdef GPIO_CAPTURE_IRQ_EN
    logic         irq;
`endif

    gpio_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gpio_in      (gpio_in),
        .ext_clk      (ext_clk),
        .use_ext_clk  (use_ext_clk),
        .ext_clk_edge (ext_clk_edge),
        .gpio_q       (gpio_q),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_mask     (evt_mask),
        .evt_data     (evt_data),
        .evt_ovf      (evt_ovf),
        .ovf_clr      (ovf_clr)
`ifdef GPIO_CAPTURE_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: input history per clk edge and a queue of stored events.
    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] data;
        int           t;
    } mevt_t;

    mevt_t        mq[$];
    logic [W-1:0] h_in[$];
    logic         h_ext[$];
    int           cyc;
    logic [W-1:0] m_q;
    logic         pend_v;
    logic [W-1:0] pend_m;
    logic [W-1:0] pend_d;
    logic         m_ovf;
    logic         m_valid;
    logic         m_irq;
    logic         pop_now;

    task automatic model_reset();
        mq.delete();
        h_in.delete();
        h_ext.delete();
        for (int i = 0; i < S + 2; i++) begin
            h_in.push_back('0);
            h_ext.push_back(1'b0);
        end
        cyc = 0; m_q = '0; pend_v = 1'b0; pend_m = '0; pend_d = '0;
        m_ovf = 1'b0; m_valid = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nq;
        logic         e_now, e_prev, take, drop;
        mevt_t        e;
        cyc++;
        m_irq = m_valid | m_ovf;
        if (pop_now && mq.size() > 0) mq.delete(0);
        drop = 1'b0;
        if (pend_v) begin
            if (mq.size() < D) begin
                e.mask = pend_m; e.data = pend_d; e.t = cyc;
                mq.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        // gpio_q after edge k reflects the pin sampled S edges earlier
        h_in.push_front(gpio_in);
        h_ext.push_front(ext_clk);
        h_in.delete(h_in.size() - 1);
        h_ext.delete(h_ext.size() - 1);
        e_now  = h_ext[S];
        e_prev = h_ext[S+1];
        for (int i = 0; i < W; i++) begin
            take = !use_ext_clk[i] || (ext_clk_edge[i] ? (e_now && !e_prev) : (!e_now && e_prev));
            nq[i] = take ? h_in[S][i] : m_q[i];
        end
        pend_v = (nq != m_q);
        pend_m = nq ^ m_q;
        pend_d = nq;
        m_q    = nq;
        m_valid = (mq.size() > 0) && (mq[0].t < cyc);
    endtask

    task automatic compare_all();
        check("gpio_q", gpio_q, m_q);
        check("evt_valid", W'(evt_valid), W'(m_valid));
        if (m_valid) begin
            check("evt_mask", evt_mask, mq[0].mask);
            check("evt_data", evt_data, mq[0].data);
        end
        check("evt_ovf", W'(evt_ovf), W'(m_ovf));
`ifdef GPIO_CAPTURE_IRQ_EN
        check("irq", W'(irq), W'(m_irq));
`endif
    endtask

    task automatic tick();
        pop_now = evt_valid && evt_ready;
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_evt(input string tag, input logic [W-1:0] em, input logic [W-1:0] ed);
        logic found;
        found = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (evt_valid) begin
                check({tag, "_mask"}, evt_mask, em);
                check({tag, "_data"}, evt_data, ed);
                found = 1'b1;
            end
            tick();
        end
        evt_ready = 1'b0;
        check({tag, "_seen"}, W'(found), W'(1'b1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, gpio_q, '0);
        check({tag, "_valid"}, W'(evt_valid), '0);
        check({tag, "_mask"}, evt_mask, '0);
        check({tag, "_data"}, evt_data, '0);
        check({tag, "_ovf"}, W'(evt_ovf), '0);
`ifdef GPIO_CAPTURE_IRQ_EN
        check({tag, "_irq"}, W'(irq), '0);
`endif
    endtask

    logic [W-1:0] vals [5];

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");

        // Plain capture: pin value applied before the first edge after release
        gpio_in = 32'hA5A5_0001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("t1_q_early", gpio_q, '0);
        tick();
        check("t1_q", gpio_q, 32'hA5A5_0001);
        tick();
        check("t1_valid_early", W'(evt_valid), '0);
        tick();
        check("t1_valid", W'(evt_valid), W'(1'b1));
        check("t1_mask", evt_mask, 32'hA5A5_0001);
        check("t1_data", evt_data, 32'hA5A5_0001);
        check("t1_ovf", W'(evt_ovf), '0);
`ifdef GPIO_CAPTURE_IRQ_EN
        check("t1_irq_lag", W'(irq), '0);
        tick();
        check("t1_irq", W'(irq), W'(1'b1));
`endif
        wait_evt("t1_evt", 32'hA5A5_0001, 32'hA5A5_0001);

        // Strobe capture: bits 3:0 on rising, 7:4 on falling ext_clk
        gpio_in = '0;
        ticks(4);
        wait_evt("t2_clear", 32'hA5A5_0001, 32'h0);
        use_ext_clk  = 32'hFF;
        ext_clk_edge = 32'h0F;
        gpio_in      = 32'hFF;
        ticks(4);
        check("t2_hold", gpio_q, '0);
        ext_clk = 1'b1;
        ticks(4);
        check("t2_rise", gpio_q, 32'h0F);
        ext_clk = 1'b0;
        ticks(4);
        check("t2_fall", gpio_q, 32'hFF);
        wait_evt("t2_evt0", 32'h0F, 32'h0F);
        wait_evt("t2_evt1", 32'hF0, 32'hFF);

        // Overflow: five changes with no consumer
        use_ext_clk  = '0;
        ext_clk_edge = '0;
        gpio_in      = '0;
        ticks(4);
        wait_evt("t3_clear", 32'hFF, 32'h0);
        vals[0] = 32'h1; vals[1] = 32'h3; vals[2] = 32'h7; vals[3] = 32'hF; vals[4] = 32'h1F;
        for (int i = 0; i < 5; i++) begin
            gpio_in = vals[i];
            ticks(3);
        end
        ticks(3);
        check("t3_ovf_set", W'(evt_ovf), W'(1'b1));
        check("t3_valid", W'(evt_valid), W'(1'b1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", W'(evt_ovf), '0);
        wait_evt("t3_e0", 32'h1, 32'h1);
        wait_evt("t3_e1", 32'h2, 32'h3);
        wait_evt("t3_e2", 32'h4, 32'h7);
        wait_evt("t3_e3", 32'h8, 32'hF);
        ticks(2);
        check("t3_empty", W'(evt_valid), '0);

        // Full FIFO: push and pop on the same edge must both be accepted
        vals[0] = 32'h0; vals[1] = 32'h100; vals[2] = 32'h300; vals[3] = 32'h700;
        for (int i = 0; i < 4; i++) begin
            gpio_in = vals[i];
            ticks(3);
        end
        gpio_in = 32'hF00;
        ticks(3);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("t4_no_ovf", W'(evt_ovf), '0);
        ticks(2);
        check("t4_no_ovf_late", W'(evt_ovf), '0);
        wait_evt("t4_e0", 32'h100, 32'h100);
        wait_evt("t4_e1", 32'h200, 32'h300);
        wait_evt("t4_e2", 32'h400, 32'h700);
        wait_evt("t4_e3", 32'h800, 32'hF00);
        tick();
        check("t4_empty", W'(evt_valid), '0);

        // Asynchronous reset with two events pending
        gpio_in = '0;
        ticks(3);
        gpio_in = 32'h5;
        ticks(5);
        check("t5_pending", W'(evt_valid), W'(1'b1));
        #1;
        rst_n   = 1'b0;
        gpio_in = '0;
        #1;
        check_all_zero("t5_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ticks(6);
        check("t5_empty", W'(evt_valid), '0);
        check("t5_q", gpio_q, '0);

        // Random traffic, alternating starved and eager consumer phases
        for (int c = 0; c < 2400; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) gpio_in = $urandom;
                else gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, W - 1));
            end
            if ($urandom_range(0, 2) == 0) ext_clk = ~ext_clk;
            if ($urandom_range(0, 99) == 0) begin
                use_ext_clk  = $urandom;
                ext_clk_edge = $urandom;
            end
            if (((c / 150) % 2) == 0) evt_ready = ($urandom_range(0, 5) == 0);
            else evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 11) == 0);
            tick();
        end
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gpio_capture.md
# gpio_capture

Receive-side GPIO input block: samples a WIDTH-bit GPIO bus and an external strobe clock `ext_clk` into the `clk` domain, and captures each bit either continuously or on a per-bit selected `ext_clk` edge. Every change of the captured value is queued as an event (change mask plus new data) in a small FIFO with a valid/ready output. It sits at the chip boundary behind the GPIO pads and is the consumer of the stimulus produced by the GPIO agent's driver.

## Interface
- `WIDTH`, 32, GPIO bus width
- `SYNC_STAGES`, 2, synchronizer depth for `gpio_in` and `ext_clk` (minimum 2)
- `FIFO_DEPTH`, 4, event FIFO entries (power of 2)
- Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1 system clock
- `rst_n` in 1 async active-low reset
- `gpio_in` in WIDTH asynchronous GPIO pins
- `ext_clk` in 1 asynchronous external capture strobe
- `use_ext_clk` in WIDTH per bit: 1 = capture on `ext_clk` edge, 0 = capture every `clk`
- `ext_clk_edge` in WIDTH per bit: 1 = rising edge, 0 = falling edge (ignored when `use_ext_clk[i]`=0)
- `gpio_q` out WIDTH current captured value
- `evt_valid` out 1 FIFO head valid
- `evt_ready` in 1 consumer accepts head
- `evt_mask` out WIDTH bits that changed in head event
- `evt_data` out WIDTH `gpio_q` value after the change
- `evt_ovf` out 1 sticky: an event was dropped on a full FIFO
- `ovf_clr` in 1 clears `evt_ovf`

## Operation
- `gpio_in` and `ext_clk` each pass through SYNC_STAGES flops giving `gpio_s`, `ext_s`; `ext_d` is `ext_s` delayed one cycle.
- `rise = ext_s & ~ext_d`; `fall = ~ext_s & ext_d`.
- Per bit i: if `use_ext_clk[i]`=0, `gpio_q[i] <= gpio_s[i]` each cycle; else `gpio_q[i] <= gpio_s[i]` only when (`ext_clk_edge[i]` ? rise : fall), otherwise hold.
- Change detect: `gpio_q_d` is `gpio_q` delayed one cycle; if `gpio_q ^ gpio_q_d` is nonzero, push {mask = xor, data = `gpio_q`}.
- FIFO pop when `evt_valid && evt_ready`. A push when full and not popping is dropped and `evt_ovf` is set. A push and pop in the same cycle on a full FIFO are both accepted.
- `evt_ovf` is set by a drop and cleared by `ovf_clr`. If both occur in the same cycle, set wins.
- Config inputs are sampled directly (quasi-static). A change takes effect on the next `clk` edge, with no glitch event beyond the resulting real `gpio_q` change.

## Timing
- Reset values: all sync flops, `gpio_q`, `gpio_q_d` and `ext_d` = 0; FIFO empty; `evt_valid`=0; `evt_mask`/`evt_data`=0; `evt_ovf`=0.
- Internal-clocked bit: `gpio_in` stable before `clk` edge N appears on `gpio_q` after edge N+SYNC_STAGES. The event is visible on `evt_valid` (empty FIFO) after edge N+SYNC_STAGES+2.
- Ext-clocked bit: the capture edge is detected SYNC_STAGES+1 cycles after the raw `ext_clk` transition, and `gpio_q` updates on that cycle. Data must be stable at least 1 `clk` before the `ext_clk` edge and held at least 1 `clk` after it.
- `ext_clk` high and low phases must each be at least 2 `clk` periods; shorter pulses may be missed.
- FIFO outputs are registered (head read from storage). `evt_valid` stays high and `evt_mask`/`evt_data` stay stable until accepted.
- After reset release, nonzero inputs generate a first event against the reset value 0.

## Configuration
- `GPIO_CAPTURE_IRQ_EN`: when defined, adds output `irq` (1 bit, reset 0) driven from a register.
  - `irq` is 1 when the FIFO is non-empty or `evt_ovf`=1; otherwise 0.
  - `irq` is updated one cycle after the condition changes.
- When `GPIO_CAPTURE_IRQ_EN` is undefined, the `irq` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `gpio_capture_pkg`:
  - default constants `GPIO_WIDTH`=32, `GPIO_SYNC_STAGES`=2, `GPIO_EVT_DEPTH`=4
  - typedef `gpio_evt_t` packed struct {mask, data}
- Sub-module `gpio_evt_fifo`: synchronous FIFO of `gpio_evt_t` with push, pop, full, empty and a registered head. The top level contains the synchronizers, edge detect, capture mux, change detect and overflow logic.

## Test plan
- Reset, all config 0, `gpio_in`=32'hA5A5_0001 → `gpio_q`=32'hA5A5_0001 after 2 clk; one event mask=32'hA5A5_0001, data=32'hA5A5_0001; `evt_ovf`=0.
- `use_ext_clk`=32'hFF, `ext_clk_edge`=32'h0F:
  - `gpio_in[7:0]` 8'h00→8'hFF, then `ext_clk` rising → `gpio_q[3:0]`=4'hF only.
  - `ext_clk` falling → `gpio_q[7:4]`=4'hF.
  - Result: two events, masks 32'h0F and 32'hF0.
- `evt_ready`=0, five distinct input changes → 4 events held, `evt_ovf`=1. `ovf_clr` pulse → `evt_ovf`=0. Drain returns the first 4 events in order.
- FIFO full with `evt_ready`=1 and a new change on the same cycle → no drop, `evt_ovf` stays 0, FIFO count stays 4.
- Assert `rst_n` low mid-event with FIFO holding 2 entries → all outputs return to 0 asynchronously and the FIFO is empty after release.
- With `GPIO_CAPTURE_IRQ_EN`: single change → `irq`=1 one cycle after `evt_valid`; `irq`=0 one cycle after the last pop.
